// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low codebook, blank pattern, decoder FSM states.
// Pure declarations; no latency, no flow control.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        HOLD   = 1'b0,
        SETTLE = 1'b1
    } seg7_state_e;

    typedef struct packed {
        logic       is_legal;
        logic       is_blank;
        logic [3:0] nibble;
    } seg7_lookup_t;

    // Encoder-side helper: digit to active-low segment pattern.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Classifies a 7-bit active-low pattern as legal digit, blank, or illegal.
// Purely combinational, no flow control.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0]   pat_i,
    output seg7_lookup_t res_o
);

    always_comb begin
        res_o.is_legal = 1'b1;
        res_o.is_blank = 1'b0;
        res_o.nibble   = 4'h0;
        case (pat_i)
            SEG_0:     res_o.nibble = 4'h0;
            SEG_1:     res_o.nibble = 4'h1;
            SEG_2:     res_o.nibble = 4'h2;
            SEG_3:     res_o.nibble = 4'h3;
            SEG_4:     res_o.nibble = 4'h4;
            SEG_5:     res_o.nibble = 4'h5;
            SEG_6:     res_o.nibble = 4'h6;
            SEG_7:     res_o.nibble = 4'h7;
            SEG_8:     res_o.nibble = 4'h8;
            SEG_9:     res_o.nibble = 4'h9;
            SEG_A:     res_o.nibble = 4'hA;
            SEG_B:     res_o.nibble = 4'hB;
            SEG_C:     res_o.nibble = 4'hC;
            SEG_D:     res_o.nibble = 4'hD;
            SEG_E:     res_o.nibble = 4'hE;
            SEG_F:     res_o.nibble = 4'hF;
            SEG_BLANK: begin
                res_o.is_legal = 1'b0;
                res_o.is_blank = 1'b1;
            end
            default:   res_o.is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Recovers the hex digit from a debounced active-low segment bus; reports digit/blank/illegal.
// Report lands STABLE_CYCLES+1 edges after first sample; no backpressure, pulses are one cycle.
module seg7_readback_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [0:6] seg,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       illegal,
    output logic [7:0] err_count
);

    localparam int unsigned     CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   STABLE_C = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   ONE_C    = CW'(1);

    logic [6:0]    seg_q;
    logic [6:0]    acc_pat_q,   acc_pat_d;
    logic [6:0]    cand_q,      cand_d;
    logic [CW-1:0] stab_cnt_q,  stab_cnt_d;
    seg7_state_e   state_q,     state_d;
    logic [3:0]    digit_q,     digit_d;
    logic          dv_q,        dv_d;
    logic          blank_q,     blank_d;
    logic          illegal_q,   illegal_d;
    logic [7:0]    err_q,       err_d;
    logic          accept;
    seg7_lookup_t  cand_class;

    seg7_pattern_lookup u_lookup (
        .pat_i (cand_d),
        .res_o (cand_class)
    );

    // Settle FSM; acceptance is decided on the same edge the count reaches the target.
    always_comb begin
        state_d    = state_q;
        stab_cnt_d = stab_cnt_q;
        cand_d     = cand_q;
        accept     = 1'b0;
        case (state_q)
            HOLD: begin
                if (seg_q != acc_pat_q) begin
                    state_d    = SETTLE;
                    stab_cnt_d = ONE_C;
                    cand_d     = seg_q;
                end
            end
            SETTLE: begin
                if (seg_q != cand_q) begin
                    cand_d     = seg_q;
                    stab_cnt_d = ONE_C;
                end else begin
                    stab_cnt_d = stab_cnt_q + ONE_C;
                end
            end
            default: begin
                state_d    = HOLD;
                stab_cnt_d = '0;
            end
        endcase
        if (state_d == SETTLE && stab_cnt_d == STABLE_C) begin
            accept     = 1'b1;
            state_d    = HOLD;
            stab_cnt_d = '0;
        end
    end

    always_comb begin
        acc_pat_d = acc_pat_q;
        digit_d   = digit_q;
        blank_d   = blank_q;
        err_d     = err_q;
        dv_d      = 1'b0;
        illegal_d = 1'b0;
        if (accept) begin
            acc_pat_d = cand_d;
            // A settle that lands back on the held pattern is a glitch, not news.
            if (cand_d != acc_pat_q) begin
                if (cand_class.is_legal) begin
                    digit_d = cand_class.nibble;
                    blank_d = 1'b0;
                    dv_d    = 1'b1;
                end else if (cand_class.is_blank) begin
                    blank_d = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q      <= SEG_BLANK;
            acc_pat_q  <= SEG_BLANK;
            cand_q     <= SEG_BLANK;
            stab_cnt_q <= '0;
            state_q    <= HOLD;
            digit_q    <= 4'h0;
            dv_q       <= 1'b0;
            blank_q    <= 1'b1;
            illegal_q  <= 1'b0;
            err_q      <= 8'h00;
        end else begin
            seg_q      <= seg;
            acc_pat_q  <= acc_pat_d;
            cand_q     <= cand_d;
            stab_cnt_q <= stab_cnt_d;
            state_q    <= state_d;
            digit_q    <= digit_d;
            dv_q       <= dv_d;
            blank_q    <= blank_d;
            illegal_q  <= illegal_d;
            err_q      <= err_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = dv_q;
    assign blank       = blank_q;
    assign illegal     = illegal_q;
    assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Randomized and directed checks of seg7_readback_decoder against a run-length reference model.
// Inputs driven on the falling edge; outputs compared 1 time unit after each rising edge.
module tb_seg7_readback_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [0:6] seg = 7'h7F;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       illegal;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int ill_cnt = 0;

    seg7_readback_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .seg         (seg),
        .digit       (digit),
        .digit_valid (digit_valid),
        .blank       (blank),
        .illegal     (illegal),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    logic [6:0] cb [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    function automatic int find_code(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (cb[i] == p) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a value that has been sampled S times in a row since the
    // last acceptance (or reset) is accepted; it is reported only if it is new.
    logic [6:0] m_sq, m_cand, m_acc;
    int         m_run, m_err, m_idx;
    logic [3:0] m_digit;
    logic       m_dv, m_ill, m_blank;

    always @(posedge clk) begin
        if (reset) begin
            m_cand = 7'h7F; m_acc = 7'h7F; m_run = 0; m_err = 0;
            m_digit = 4'h0; m_dv = 1'b0; m_ill = 1'b0; m_blank = 1'b1;
            m_sq = 7'h7F;
        end else begin
            m_dv = 1'b0;
            m_ill = 1'b0;
            if (m_run > 0 && m_sq == m_cand) m_run++;
            else begin
                m_cand = m_sq;
                m_run  = 1;
            end
            if (m_run == S) begin
                if (m_cand != m_acc) begin
                    m_idx = find_code(m_cand);
                    if (m_idx >= 0) begin
                        m_digit = m_idx[3:0];
                        m_blank = 1'b0;
                        m_dv    = 1'b1;
                    end else if (m_cand == 7'h7F) begin
                        m_blank = 1'b1;
                    end else begin
                        m_ill = 1'b1;
                        if (m_err < 255) m_err++;
                    end
                end
                m_acc = m_cand;
                m_run = 0;
            end
            m_sq = seg;
        end
        #1;
        chk("digit", int'(digit), int'(m_digit));
        chk("digit_valid", int'(digit_valid), int'(m_dv));
        chk("blank", int'(blank), int'(m_blank));
        chk("illegal", int'(illegal), int'(m_ill));
        chk("err_count", int'(err_count), m_err);
        chk("dv_and_illegal_exclusive", int'(digit_valid & illegal), 0);
        if (digit_valid) dv_cnt++;
        if (illegal) ill_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [6:0] v);
        @(negedge clk);
        seg = v;
    endtask

    int d0, i0, kind, hold;
    logic [6:0] pat;

    initial begin
        tick(3);
        @(negedge clk) reset = 1'b0;
        tick(2);
        chk("rst_digit", int'(digit), 0);
        chk("rst_blank", int'(blank), 1);
        chk("rst_err", int'(err_count), 0);
        chk("rst_dv", int'(digit_valid), 0);

        // 12 held: report exactly at e5
        drive(7'h12);
        tick(4);
        chk("t1_no_early_dv", int'(digit_valid), 0);
        tick(1);
        chk("t1_dv", int'(digit_valid), 1);
        chk("t1_digit", int'(digit), 2);
        chk("t1_blank", int'(blank), 0);
        chk("t1_model_digit", int'(m_digit), 2);
        tick(1);
        chk("t1_dv_one_cycle", int'(digit_valid), 0);

        // 06 too short, then 4C held
        drive(7'h06);
        tick(2);
        drive(7'h4C);
        d0 = dv_cnt;
        tick(4);
        chk("t2_no_report_06", dv_cnt - d0, 0);
        tick(1);
        chk("t2_dv", int'(digit_valid), 1);
        chk("t2_digit", int'(digit), 4);

        // glitch back to held pattern
        drive(7'h24);
        tick(6);
        chk("t3_digit5", int'(digit), 5);
        d0 = dv_cnt;
        drive(7'h00);
        tick(1);
        drive(7'h24);
        tick(8);
        chk("t3_no_dv", dv_cnt - d0, 0);
        chk("t3_digit_stays", int'(digit), 5);

        // blank after digit 9
        drive(7'h04);
        tick(6);
        chk("t4_digit9", int'(digit), 9);
        d0 = dv_cnt;
        drive(7'h7F);
        tick(6);
        chk("t4_blank", int'(blank), 1);
        chk("t4_digit_holds", int'(digit), 9);
        chk("t4_no_dv", dv_cnt - d0, 0);

        // illegal saturation
        i0 = ill_cnt;
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 7'h55 : 7'h2A);
            tick(5);
        end
        chk("t5_ill_pulses", ill_cnt - i0, 300);
        chk("t5_err_sat", int'(err_count), 255);
        chk("t5_model_err", m_err, 255);

        // reset mid-settle of 38
        drive(7'h38);
        tick(2);
        @(negedge clk);
        reset = 1'b1;
        seg   = 7'h7F;
        tick(2);
        chk("t6_rst_err", int'(err_count), 0);
        chk("t6_rst_blank", int'(blank), 1);
        chk("t6_rst_digit", int'(digit), 0);
        @(negedge clk) reset = 1'b0;
        d0 = dv_cnt;
        i0 = ill_cnt;
        tick(10);
        chk("t6_no_report", (dv_cnt - d0) + (ill_cnt - i0), 0);
        chk("t6_digit_after", int'(digit), 0);

        // randomized patterns and hold lengths, occasional reset
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) pat = cb[$urandom_range(0, 15)];
            else if (kind < 7) pat = 7'h7F;
            else begin
                pat = 7'($urandom_range(0, 127));
                while (find_code(pat) >= 0 || pat == 7'h7F) pat = 7'($urandom_range(0, 127));
            end
            hold = $urandom_range(1, 7);
            @(negedge clk);
            seg   = pat;
            reset = ($urandom_range(0, 39) == 0);
            tick(1);
            @(negedge clk) reset = 1'b0;
            tick(hold);
        end
        tick(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_readback_decoder.md
# seg7_readback_decoder

Recovers the 4-bit hex digit from an active-low 7-segment drive pattern, the reverse of the DDS digit-to-segment encoding. It sits on the display path of the DDS board as a readback monitor. It samples the segment bus, requires a pattern to be stable before accepting it, and reports each newly accepted digit, the blank state, and any illegal pattern. The tuning-word logic and the test harness use it to confirm what the display is actually showing.

## Interface
- STABLE_CYCLES, default 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- seg  in  [0:6]  segment drive, bit 0 = segment a … bit 6 = segment g; active-low (0 = lit).
- digit  out  4  last accepted legal digit.
- digit_valid  out  1  one-cycle pulse when a new legal digit is accepted.
- blank  out  1  level; high while the accepted pattern is 7'h7F.
- illegal  out  1  one-cycle pulse when a stable pattern is not in the codebook.
- err_count  out  8  count of illegal acceptances; saturates at 255.

## Operation
- Codebook, value→digit: 01→0, 4F→1, 12→2, 06→3, 4C→4, 24→5, 20→6, 0F→7, 00→8, 04→9, 08→A, 60→B, 31→C, 42→D, 30→E, 38→F. 7F is blank. Every other pattern is illegal.
- seg is registered once into seg_q; all logic uses seg_q.
- Internal registers:
  - acc_pat: last accepted pattern.
  - stab_cnt: stability counter, width clog2(STABLE_CYCLES+1).
  - state: HOLD or SETTLE.
- HOLD behaviour:
  - If seg_q equals acc_pat: stay in HOLD.
  - If seg_q differs: go to SETTLE, stab_cnt=1, cand=seg_q.
- SETTLE behaviour:
  - If seg_q differs from cand: cand=seg_q, stab_cnt=1. The restart applies even if seg_q equals acc_pat.
  - If seg_q equals cand: increment stab_cnt.
  - When stab_cnt reaches STABLE_CYCLES, classify cand and return to HOLD.
- Classification on acceptance:
  - If cand equals acc_pat, nothing is reported. This covers a glitch that returns to the held pattern.
  - Legal digit: digit=value, blank=0, digit_valid pulse.
  - Blank: blank=1, digit holds its value, no pulse.
  - Illegal: illegal pulse, err_count+1 (saturating), digit and blank hold.
  - In every case acc_pat=cand.
- Reset values: seg_q=7F, acc_pat=7F, cand=7F, state=HOLD, stab_cnt=0, digit=0, digit_valid=0, blank=1, illegal=0, err_count=0.
- Reset has priority over all other activity, including mid-SETTLE. A partial settle is discarded.
- The err_count saturation boundary: at 255, further illegal acceptances still pulse illegal, but the count stays at 255.

## Timing
- Pattern sampling: a pattern is first present in seg_q after sampling edge e1. If seg holds it through edges e1..e_STABLE_CYCLES, the outputs update at edge e_(STABLE_CYCLES+1).
  - Example, default STABLE_CYCLES=4: seg applied before e1, pulse high between e5 and e6.
- digit_valid and illegal are exactly one cycle wide and are never high in the same cycle.
- A back-to-back different stable pattern produces its report STABLE_CYCLES+1 edges after its first sample.
- The minimum spacing between reports is STABLE_CYCLES cycles.
- A change of seg on any edge before acceptance restarts the count with no output activity.
- All outputs are registered. There are no combinational paths from seg to the outputs.

## Structure
- seg7_pkg, shared with the encoder side, holds:
  - the 16 codebook constants;
  - SEG_BLANK=7'h7F;
  - the state enum {HOLD, SETTLE}.
- Sub-module seg7_pattern_lookup: purely combinational, 7-bit pattern → {is_legal, is_blank, nibble}.
- The top level holds the sampling register, the FSM, the counters, and the output registers.

## Test plan
- Reset, then drive seg=12 held: digit_valid pulses at e5 with digit=2 and blank=0. Nothing else pulses.
- Drive 06 for 2 cycles, then 4C held: no report for 06. digit=4 is reported 5 edges after 4C is first sampled.
- Hold 24 (digit 5 accepted), glitch to 00 for 1 cycle, return to 24: no digit_valid, digit stays 5.
- Drive 7F after an accepted digit 9: blank rises at acceptance, digit stays 9, no pulse.
- Drive 300 separate stable illegal patterns, alternating 55 and 2A: illegal pulses 300 times and err_count saturates at 255.
- Assert reset during SETTLE of 38: all outputs return to reset values, and no report for 38 ever appears.
